// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and mem-access stages.
// Data wins by default; a saturating starvation counter forces fetch progress.
module mem_port_arbiter #(
  parameter int INSTR_WIDTH    = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
  input  logic                      if_flush,
  output logic [INSTR_WIDTH-1:0]    if_rdata,
  output logic                      if_valid,
  output logic                      if_stall,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [MEM_ADDR_WIDTH-1:0] d_addr,
  input  logic [INSTR_WIDTH-1:0]    d_wdata,
  output logic [INSTR_WIDTH-1:0]    d_rdata,
  output logic                      d_valid,
  output logic                      d_stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]    mem_wdata,
  input  logic [INSTR_WIDTH-1:0]    mem_rdata,
  input  logic                      mem_ack
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF    = 2'd1;
  localparam logic [1:0] S_D     = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_done;

  logic w_arb;
  logic w_starved;
  logic w_if_win;
  logic w_grant_if;
  logic w_grant_d;

  // r_done blocks arbitration on the completion cycle, so a request
  // still held while its valid pulses is not granted a second time.
  assign w_arb      = (r_state == S_IDLE) && !r_done && (if_req || d_req);
  assign w_starved  = (r_starve_cnt == CW'(STARVE_LIMIT));
  assign w_if_win   = if_req && (!d_req || w_starved);
  assign w_grant_if = w_arb && w_if_win;
  assign w_grant_d  = w_arb && !w_if_win;

  assign if_stall = rst && if_req && !if_valid;
  assign d_stall  = rst && d_req && !d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_done       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      if_valid     <= 1'b0;
      d_rdata      <= '0;
      d_valid      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            r_starve_cnt <= '0;
            r_state      <= if_flush ? S_DROP : S_IF;
          end else if (w_grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && !w_starved)
              r_starve_cnt <= r_starve_cnt + CW'(1);
            r_state   <= S_D;
          end
        end
        S_IF: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (!if_flush) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            r_state <= S_DROP;
          end
        end
        S_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_done  <= 1'b1;
            d_valid <= 1'b1;
            if (!mem_we)
              d_rdata <= mem_rdata;
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory.
// Each task drives one scenario and checks outputs cycle by cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  bit          auto_en = 1'b1;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] rdata_val = '0;

  mem_port_arbiter #(
    .INSTR_WIDTH(32),
    .MEM_ADDR_WIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Memory: acks lat cycles after mem_req is first seen.
  always @(posedge clk) begin
    #1;
    if (auto_en) begin
      mem_ack = 1'b0;
      if (!rst || !mem_req) begin
        cnt = 0;
      end else if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
        cnt       = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_req = 1'b1;
    d_req  = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mem_req, mem_we, if_valid, d_valid, if_stall, d_stall} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {mem_req, mem_we, if_valid, d_valid, if_stall, d_stall});
    end
    n_chk++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    cyc();
    if_req = 1'b0;
    d_req  = 1'b0;
    rst    = 1'b1;
    cyc();
  endtask

  task automatic test_single_fetch();
    lat = 1;
    rdata_val = 32'hDEADBEEF;
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h10;
    @(negedge clk);
    n_chk++;
    if (if_stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sf_c0: stall=%b req=%b want stall=1 req=0", if_stall, mem_req);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sf_c1: req=%b addr=%h we=%b stall=%b want 1 10 0 1",
               mem_req, mem_addr, mem_we, if_stall);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sf_c2: valid=%b stall=%b want 0 1", if_valid, if_stall);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_stall !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sf_c3: valid=%b rdata=%h stall=%b req=%b want 1 deadbeef 0 0",
               if_valid, if_rdata, if_stall, mem_req);
    end
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sf_c4: valid=%b req=%b want 0 0", if_valid, mem_req);
    end
    cyc();
  endtask

  task automatic test_simultaneous();
    lat = 1;
    rdata_val = 32'hCAFE0001;
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h20;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h200;
    cyc();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_dgrant: req=%b addr=%h we=%b want 1 200 0", mem_req, mem_addr, mem_we);
    end
    n_chk++;
    if (dut.r_starve_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL sim_starve1: got %0d want 1", dut.r_starve_cnt);
    end
    cyc();
    cyc();
    @(negedge clk);
    n_chk++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE0001 || if_valid !== 1'b0 || if_stall !== 1'b1 || d_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_dvalid: dv=%b rd=%h iv=%b is=%b ds=%b want 1 cafe0001 0 1 0",
               d_valid, d_rdata, if_valid, if_stall, d_stall);
    end
    cyc();
    d_req = 1'b0;
    rdata_val = 32'h0BAD0002;
    cyc();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20 || dut.r_starve_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL sim_fgrant: req=%b addr=%h cnt=%0d want 1 20 0",
               mem_req, mem_addr, dut.r_starve_cnt);
    end
    cyc();
    cyc();
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0BAD0002) begin
      n_fail++;
      $display("FAIL sim_fvalid: valid=%b rdata=%h want 1 0bad0002", if_valid, if_rdata);
    end
    cyc();
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    logic [31:0] g_addr [8];
    int   n_g;
    int   n_iv;
    logic prev;
    lat = 1;
    rdata_val = 32'h5555AAAA;
    n_g  = 0;
    n_iv = 0;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (c == 0) begin
        if_req  = 1'b1;
        if_addr = 32'h300;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h400;
      end
      @(negedge clk);
      if (mem_req && !prev && n_g < 8) begin
        g_addr[n_g] = mem_addr;
        n_g++;
      end
      if (if_valid) n_iv++;
      prev = mem_req;
    end
    cyc();
    if_req = 1'b0;
    d_req  = 1'b0;
    n_chk++;
    if (n_g !== 5) begin
      n_fail++;
      $display("FAIL starve_ngrant: got %0d want 5", n_g);
    end
    for (int i = 0; i < 5 && i < n_g; i++) begin
      n_chk++;
      if (g_addr[i] !== ((i < 4) ? 32'h400 : 32'h300)) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got %h want %h", i, g_addr[i],
                 (i < 4) ? 32'h400 : 32'h300);
      end
    end
    n_chk++;
    if (n_iv !== 1 || dut.r_starve_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL starve_fetch: ivalids=%0d cnt=%0d want 1 0", n_iv, dut.r_starve_cnt);
    end
    cyc();
    cyc();
  endtask

  task automatic test_store();
    lat = 5;
    rdata_val = 32'hFFFFFFFF;
    cyc();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'h1234;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      @(negedge clk);
      n_chk++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'h1234 || d_valid !== 1'b0 || d_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL store_hold_c%0d: req=%b we=%b addr=%h wd=%h dv=%b ds=%b",
                 c, mem_req, mem_we, mem_addr, mem_wdata, d_valid, d_stall);
      end
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h5555AAAA || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done: dv=%b rd=%h req=%b want 1 5555aaaa 0", d_valid, d_rdata, mem_req);
    end
    cyc();
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (d_valid !== 1'b0 || d_rdata !== 32'h5555AAAA) begin
      n_fail++;
      $display("FAIL store_once: dv=%b rd=%h want 0 5555aaaa", d_valid, d_rdata);
    end
    cyc();
  endtask

  task automatic test_flush();
    int n_iv;
    n_iv = 0;
    lat = 3;
    rdata_val = 32'h77777777;
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h60;
    cyc();
    if_flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin
      n_fail++;
      $display("FAIL flush_grant: req=%b addr=%h want 1 60", mem_req, mem_addr);
    end
    cyc();
    if_flush = 1'b0;
    if_addr  = 32'h80;
    @(negedge clk);
    if (if_valid) n_iv++;
    n_chk++;
    if (mem_addr !== 32'h60 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hold: req=%b addr=%h want 1 60", mem_req, mem_addr);
    end
    for (int c = 3; c <= 4; c++) begin
      cyc();
      @(negedge clk);
      if (if_valid) n_iv++;
    end
    cyc();
    lat = 1;
    rdata_val = 32'h80808080;
    @(negedge clk);
    if (if_valid) n_iv++;
    n_chk++;
    if (mem_req !== 1'b0 || if_rdata !== 32'h5555AAAA || if_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drop: req=%b rd=%h stall=%b want 0 5555aaaa 1",
               mem_req, if_rdata, if_stall);
    end
    for (int c = 6; c <= 8; c++) begin
      cyc();
      @(negedge clk);
      if (if_valid) n_iv++;
      if (c == 7) begin
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
          n_fail++;
          $display("FAIL flush_refetch: req=%b addr=%h want 1 80", mem_req, mem_addr);
        end
      end
    end
    n_chk++;
    if (n_iv !== 0) begin
      n_fail++;
      $display("FAIL flush_novalid: got %0d pulses want 0", n_iv);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h80808080) begin
      n_fail++;
      $display("FAIL flush_newfetch: valid=%b rd=%h want 1 80808080", if_valid, if_rdata);
    end
    cyc();
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    auto_en = 1'b0;
    mem_ack = 1'b0;
    cyc();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h500;
    cyc();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL rst_busy: req=%b addr=%h want 1 500", mem_req, mem_addr);
    end
    cyc();
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || d_valid !== 1'b0 || d_stall !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b dv=%b ds=%b rd=%h want 0 0 0 0",
               mem_req, d_valid, d_stall, d_rdata);
    end
    d_req = 1'b0;
    cyc();
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h99999999;
    cyc();
    mem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (mem_req !== 1'b0 || d_valid !== 1'b0 || if_valid !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_lateack%0d: req=%b dv=%b iv=%b drd=%h ird=%h want all 0",
                 c, mem_req, d_valid, if_valid, d_rdata, if_rdata);
      end
      cyc();
    end
    auto_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
